// File: rtl/mdu_seq_pkg.sv
// rtl/mdu_seq_pkg.sv - MDU opcodes, default latencies and launch-op helpers (MDU_MADD_EN gates madd/msub acceptance)
package mdu_seq_pkg;

  // Operation codes; 0 and 13..15 are undefined
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;
  localparam logic [3:0] MDU_MADDU = 4'd10;
  localparam logic [3:0] MDU_MSUB  = 4'd11;
  localparam logic [3:0] MDU_MSUBU = 4'd12;

  // Default busy latencies
  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // Latency counter width
  localparam int MDU_CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for ops that a start strobe launches into the multi-cycle engine
  function automatic logic is_launch_op(input logic [3:0] op);
    logic ok;
    ok = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
`ifdef MDU_MADD_EN
    ok = ok || (op == MDU_MADD) || (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    return ok;
  endfunction

  // True for divide ops, which use the longer latency
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_seq_calc.sv
// rtl/mdu_seq_calc.sv - combinational 64-bit HI/LO result generator (MDU_MADD_EN adds accumulate ops)
module mdu_seq_calc
  import mdu_seq_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
`ifdef MDU_MADD_EN
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
`endif
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div0_o
);

  logic        mul_sgn;
  logic        div_sgn;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvs;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quo;
  logic [31:0] rem;

  // Shared multiplier: sign- or zero-extend to 64 bits so the low 64 product bits are exact
  always_comb begin
    mul_sgn = (op_i == MDU_MULT) || (op_i == MDU_MADD) || (op_i == MDU_MSUB);
    ext_a   = mul_sgn ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
    ext_b   = mul_sgn ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
    prod    = ext_a * ext_b;
  end

  // Divider on magnitudes; signs restored after, so INT_MIN / -1 wraps to INT_MIN with rem 0
  always_comb begin
    div_sgn = (op_i == MDU_DIV);
    mag_a   = (div_sgn && a_i[31]) ? (~a_i + 32'd1) : a_i;
    mag_b   = (div_sgn && b_i[31]) ? (~b_i + 32'd1) : b_i;
    dvs     = (b_i == 32'd0) ? 32'd1 : mag_b;
    q_u     = mag_a / dvs;
    r_u     = mag_a % dvs;
    quo     = (div_sgn && (a_i[31] ^ b_i[31])) ? (~q_u + 32'd1) : q_u;
    rem     = (div_sgn && a_i[31]) ? (~r_u + 32'd1) : r_u;
  end

  // Select the result for the requested op; div0 tells the owner to keep HI/LO
  always_comb begin
    hi_o   = 32'd0;
    lo_o   = 32'd0;
    div0_o = 1'b0;
    case (op_i)
      MDU_MULT, MDU_MULTU: {hi_o, lo_o} = prod;
      MDU_DIV, MDU_DIVU: begin
        hi_o   = rem;
        lo_o   = quo;
        div0_o = (b_i == 32'd0);
      end
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU: {hi_o, lo_o} = {hi_i, lo_i} + prod;
      MDU_MSUB, MDU_MSUBU: {hi_o, lo_o} = {hi_i, lo_i} - prod;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multi-cycle multiply/divide unit with HI/LO registers (MDU_MADD_EN enables madd/msub)
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rd_data
);

  mdu_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [31:0]          a_q, a_d;
  logic [31:0]          b_q, b_d;
  logic [31:0]          hi_q, hi_d;
  logic [31:0]          lo_q, lo_d;

  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_div0;

  // Result is formed from the captured operands and, for accumulate ops, HI/LO as they stand at commit
  mdu_seq_calc u_calc (
    .op_i   (op_q),
    .a_i    (a_q),
    .b_i    (b_q),
`ifdef MDU_MADD_EN
    .hi_i   (hi_q),
    .lo_i   (lo_q),
`endif
    .hi_o   (calc_hi),
    .lo_o   (calc_lo),
    .div0_o (calc_div0)
  );

  // Next-state: launch, count down, commit; mthi/mtlo only while idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && is_launch_op(mdu_op)) begin
          state_d = ST_RUN;
          cnt_d   = is_div_op(mdu_op) ? MDU_CNT_W'(DIV_CYCLES) : MDU_CNT_W'(MULT_CYCLES);
          op_d    = mdu_op;
          a_d     = A;
          b_d     = B;
        end
        if (mdu_op == MDU_MTHI) hi_d = A;
        if (mdu_op == MDU_MTLO) lo_d = A;
      end
      ST_RUN: begin
        if (cnt_q == MDU_CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          op_d    = MDU_NONE;
          a_d     = 32'd0;
          b_d     = 32'd0;
          if (!calc_div0) begin
            hi_d = calc_hi;
            lo_d = calc_lo;
          end
        end else begin
          cnt_d = cnt_q - MDU_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, pending operands and architectural HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Outputs; mfhi/mflo read the register directly, so stale values show while busy
  always_comb begin
    busy    = (state_q == ST_RUN);
    HI      = hi_q;
    LO      = lo_q;
    rd_data = 32'd0;
    if (mdu_op == MDU_MFHI) rd_data = hi_q;
    if (mdu_op == MDU_MFLO) rd_data = lo_q;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide unit. It sits beside the combinational ALU in the EX stage and services mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- Accepts a one-cycle start pulse with operands and asserts busy for a fixed latency. It then commits HI/LO.
- The pipeline stalls any MDU instruction in D while start or busy is high.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle launch strobe for mult/multu/div/divu; ignored for other ops.
- mdu_op  input  4  operation code, from def.v macros.
- A  input  32  rs operand.
- B  input  32  rt operand.
- busy  output  1  high while a multi-cycle op is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- rd_data  output  32  combinational: HI when mdu_op = MDU_mfhi, LO when MDU_mflo, else 0.

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, busy=0, counter=0, state=IDLE, pending result cleared.
- States:
  - IDLE to RUN on start=1 with mdu_op in {mult, multu, div, divu}.
  - RUN to IDLE when the counter reaches 1.
- Launch: on the start edge, capture A and B. Compute the 64-bit pending result from the captured operands:
  - mult: signed 32x32 to 64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 to 64.
  - div: LO=signed quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Counter loads MULT_CYCLES or DIV_CYCLES.
- busy rises the cycle after the start edge and stays high for exactly N cycles.
- HI/LO update on the same edge where busy falls, so the result is visible in the first cycle busy=0.
- Divide by zero (B=0 for div/divu): full latency is still spent; HI and LO are left unchanged.
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- start while busy: ignored; the in-flight op is unaffected. The pipeline must not do this; the bench flags it as a protocol warning.
- mthi/mtlo: single-cycle and act only when busy=0. HI<=A or LO<=A at the next edge, independent of start. While busy, they are ignored.
- mfhi/mflo: purely combinational. While busy, rd_data shows the old HI/LO; the pipeline stalls such instructions.
- Simultaneous start and mthi/mtlo in the same cycle is impossible because the op field is shared.
- Reset mid-operation: the in-flight result is discarded and all state returns to reset values immediately.
- Undefined mdu_op: no state change; rd_data=0.

Optional Feature:
- Macro MDU_MADD_EN.
- When defined, ops MDU_madd, MDU_maddu, MDU_msub, MDU_msubu are accepted with start. The product is computed as for mult/multu, then {HI,LO} is added or subtracted modulo 2^64. The {HI,LO} value used is the one present at commit, not at launch. Latency is MULT_CYCLES.
- When undefined, these codes are treated as undefined ops: start has no effect and busy stays 0.

Decomposition:
- def.v holds all MDU_* opcode macros (4-bit): mult, multu, div, divu, mfhi, mflo, mthi, mtlo, and madd/maddu/msub/msubu under the macro. It also holds default latency macros alongside the existing ALU_* codes.
- One natural sub-module: mdu_calc, a combinational 64-bit result generator taking op, A, B, and current HI/LO, and returning {hi,lo,div0}.
- The top module keeps the state machine, counter, and HI/LO registers.

Test Plan:
- Reset, then start mult with A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- start divu with A=100, B=7 -> busy for 10 cycles; then LO=14, HI=2. Also start div with A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Preload with mtlo 0x1234 and mthi 0x5678, then start div with B=0 -> busy for 10 cycles; HI=0x5678 and LO=0x1234 unchanged afterwards.
- Second start plus mthi 0xDEAD issued while busy from multu 0x10000 x 0x10000 -> both ignored; result HI=1, LO=0.
- Assert reset at cycle 3 of a divu -> busy=0, HI=LO=0 immediately; a new mult afterwards completes normally.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 -> HI=1, LO=0. Without the macro the same op leaves busy=0 and HI/LO unchanged.
